// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state, owner, range check.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    IDLE      = 1'b0,
    DMA_BURST = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  function automatic logic in_range(
    input logic [ADDR_W-1:0] addr,
    input int unsigned       depth
  );
    return addr < depth;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between requesters (core, DMA), arbiter and data memory.
// slave: arbiter side; master: requester/memory side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LEN_W = 4
);
  logic              core_req_i;
  logic              core_we_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic [DATA_W-1:0] core_rdata_o;
  logic              core_err_o;

  logic              dma_req_i;
  logic              dma_we_i;
  logic [ADDR_W-1:0] dma_addr_i;
  logic [LEN_W-1:0]  dma_len_i;
  logic [DATA_W-1:0] dma_wdata_i;
  logic              dma_gnt_o;
  logic              dma_beat_o;
  logic [LEN_W-1:0]  dma_idx_o;
  logic              dma_rvalid_o;
  logic [DATA_W-1:0] dma_rdata_o;
  logic              dma_done_o;
  logic              dma_err_o;

  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_len_i, dma_wdata_i,
    output dma_gnt_o, dma_beat_o, dma_idx_o, dma_rvalid_o,
    output dma_rdata_o, dma_done_o, dma_err_o,
    output mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    output dma_req_i, dma_we_i, dma_addr_i, dma_len_i, dma_wdata_i,
    input  dma_gnt_o, dma_beat_o, dma_idx_o, dma_rvalid_o,
    input  dma_rdata_o, dma_done_o, dma_err_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_burst_counter.sv
// DMA burst beat counter: latches base/len on start, emits idx/addr/last.
// Ports: start_i, step_i (beat issued), base_i, len_i -> idx_o, addr_o, last_o.
module dmem_burst_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned ADDR_INC = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [LEN_W-1:0]  idx_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  // The start cycle issues beat 0 straight from the request inputs.
  always_comb begin
    base_d = start_i ? base_i : base_q;
    len_d  = start_i ? len_i : len_q;
    idx_o  = start_i ? '0 : idx_q;
    addr_o = base_d + 32'(idx_o) * 32'(ADDR_INC);
    last_o = (idx_o == len_d);
    idx_d  = idx_q;
    if (step_i) begin
      idx_d = last_o ? '0 : idx_o + LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between core and DMA bursts.
// Ports: clk_i, reset_ni, bus (slave). Option: DMEM_ARB_RR_EN = round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned ADDR_INC = 1
) (
  input logic           clk_i,
  input logic           reset_ni,
  dmem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              idle, core_win;
  logic              core_gnt, dma_gnt, beat;
  logic              core_ok, beat_ok, beat_we;
  logic [LEN_W-1:0]  beat_idx;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_last;

  logic              dma_we_q, dma_we_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic              core_err_q, core_err_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_done_q, dma_done_d;
  logic              dma_err_q, dma_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef DMEM_ARB_RR_EN
  // Owner preferred on a tie; flips to the other side on every grant.
  owner_e prio_q, prio_d;

  always_comb begin
    core_win = !bus.dma_req_i || (prio_q == OWN_CORE);
    prio_d   = prio_q;
    if (core_gnt) prio_d = OWN_DMA;
    if (dma_gnt)  prio_d = OWN_CORE;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) prio_q <= OWN_CORE;
    else           prio_q <= prio_d;
  end
`else
  assign core_win = 1'b1;
`endif

  dmem_burst_counter #(
    .LEN_W   (LEN_W),
    .ADDR_INC(ADDR_INC)
  ) u_cnt (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .start_i (dma_gnt),
    .step_i  (beat),
    .base_i  (bus.dma_addr_i),
    .len_i   (bus.dma_len_i),
    .idx_o   (beat_idx),
    .addr_o  (beat_addr),
    .last_o  (beat_last)
  );

  // Grants are gated by reset so all outputs drop while it is held.
  always_comb begin
    idle     = reset_ni && (state_q == IDLE);
    core_gnt = idle && bus.core_req_i && core_win;
    dma_gnt  = idle && bus.dma_req_i && !core_gnt;
    beat     = dma_gnt || (reset_ni && (state_q == DMA_BURST));
    beat_we  = dma_gnt ? bus.dma_we_i : dma_we_q;
    dma_we_d = beat_we;
    core_ok  = in_range(bus.core_addr_i, DEPTH);
    beat_ok  = in_range(beat_addr, DEPTH);

    state_d = state_q;
    if (dma_gnt && !beat_last) state_d = DMA_BURST;
    if ((state_q == DMA_BURST) && beat_last) state_d = IDLE;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      core_gnt: begin
        mem_we    = bus.core_we_i && core_ok;
        mem_addr  = bus.core_addr_i;
        mem_wdata = bus.core_we_i ? bus.core_wdata_i : '0;
      end
      beat: begin
        mem_we    = beat_we && beat_ok;
        mem_addr  = beat_addr;
        mem_wdata = beat_we ? bus.dma_wdata_i : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    core_rvalid_d = core_gnt;
    core_rdata_d  = (core_gnt && !bus.core_we_i && core_ok) ?
                    bus.mem_rdata_i : '0;
    core_err_d    = core_gnt && !core_ok;
    dma_rvalid_d  = beat && !beat_we;
    dma_rdata_d   = (beat && !beat_we && beat_ok) ?
                    bus.mem_rdata_i : '0;
    dma_done_d    = beat && beat_last;
    dma_err_d     = dma_gnt ? !beat_ok :
                    (dma_err_q || (beat && !beat_ok));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      dma_we_q      <= 1'b0;
      core_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      core_err_q    <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      dma_rdata_q   <= '0;
      dma_done_q    <= 1'b0;
      dma_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dma_we_q      <= dma_we_d;
      core_rvalid_q <= core_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      core_err_q    <= core_err_d;
      dma_rvalid_q  <= dma_rvalid_d;
      dma_rdata_q   <= dma_rdata_d;
      dma_done_q    <= dma_done_d;
      dma_err_q     <= dma_err_d;
    end
  end

  assign bus.core_gnt_o    = core_gnt;
  assign bus.core_rvalid_o = core_rvalid_q;
  assign bus.core_rdata_o  = core_rdata_q;
  assign bus.core_err_o    = core_err_q;
  assign bus.dma_gnt_o     = dma_gnt;
  assign bus.dma_beat_o    = beat;
  assign bus.dma_idx_o     = beat ? beat_idx : '0;
  assign bus.dma_rvalid_o  = dma_rvalid_q;
  assign bus.dma_rdata_o   = dma_rdata_q;
  assign bus.dma_done_o    = dma_done_q;
  // A new grant clears the previous burst's error at once.
  assign bus.dma_err_o     = dma_err_q && !dma_gnt;
  assign bus.mem_we_o      = mem_we;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_wdata_o   = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a word-array memory model.
// Honours DMEM_ARB_RR_EN for the expected tie-break order.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.LEN_W(4)) bus ();

  dmem_arbiter #(
    .DEPTH(1024), .LEN_W(4), .ADDR_INC(1)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        mem_init = 1'b1;
  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] seed(input int i);
    return 32'(i) * 32'h9E37_79B9 ^ 32'hA5A5_0000;
  endfunction

  assign bus.mem_rdata_i = (bus.mem_addr_o < 1024) ?
    mem[bus.mem_addr_o[9:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed(i);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (bus.mem_we_o && bus.mem_addr_o < 1024) begin
      mem[bus.mem_addr_o[9:0]] <= bus.mem_wdata_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.core_req_i = 0; bus.core_we_i = 0;
    bus.core_addr_i = 0; bus.core_wdata_i = 0;
    bus.dma_req_i = 0; bus.dma_we_i = 0; bus.dma_addr_i = 0;
    bus.dma_len_i = 0; bus.dma_wdata_i = 0;
  endtask

  task automatic test_reset();
    clr();
    bus.core_req_i = 1; bus.dma_req_i = 1;
    @(negedge clk);
    total++;
    if ({bus.core_gnt_o, bus.dma_gnt_o, bus.dma_beat_o, bus.mem_we_o,
         bus.core_rvalid_o, bus.dma_done_o, bus.dma_err_o,
         bus.dma_rvalid_o, bus.mem_addr_o} !== '0) begin
      bad++; $display("FAIL reset_outputs gnt=%b/%b beat=%b we=%b addr=%h want 0",
        bus.core_gnt_o, bus.dma_gnt_o, bus.dma_beat_o, bus.mem_we_o, bus.mem_addr_o);
    end
    tick();
    mem_init = 0; clr(); rst_n = 1;
    @(negedge clk);
    total++;
    if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
         bus.core_rvalid_o, bus.dma_beat_o} !== '0) begin
      bad++; $display("FAIL idle_outputs we=%b addr=%h wdata=%h want 0",
        bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    tick();
  endtask

  task automatic test_core_read();
    poke_en = 1; poke_addr = 10'd5; poke_data = 32'hDEADBEEF;
    tick();
    poke_en = 0; ref_mem[5] = 32'hDEADBEEF;
    bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 5;
    @(negedge clk);
    total++;
    if (bus.core_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'd5 || bus.mem_we_o !== 1'b0) begin
      bad++; $display("FAIL rd5_issue gnt=%b addr=%h we=%b want 1/5/0",
        bus.core_gnt_o, bus.mem_addr_o, bus.mem_we_o);
    end
    tick();
    bus.core_req_i = 0;
    @(negedge clk);
    total++;
    if (bus.core_rvalid_o !== 1'b1 || bus.core_rdata_o !== 32'hDEADBEEF ||
        bus.core_err_o !== 1'b0) begin
      bad++; $display("FAIL rd5_ack rvalid=%b rdata=%h err=%b want 1/deadbeef/0",
        bus.core_rvalid_o, bus.core_rdata_o, bus.core_err_o);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.core_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL rd5_rvalid_drop rvalid=%b want 0", bus.core_rvalid_o);
    end
    tick();
  endtask

  task automatic test_core_oob_write();
    bus.core_req_i = 1; bus.core_we_i = 1;
    bus.core_addr_i = 32'd1024; bus.core_wdata_i = 32'h1234_5678;
    @(negedge clk);
    total++;
    if (bus.core_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin
      bad++; $display("FAIL oob_wr_issue gnt=%b we=%b want 1/0",
        bus.core_gnt_o, bus.mem_we_o);
    end
    tick();
    clr();
    @(negedge clk);
    total++;
    if (bus.core_rvalid_o !== 1'b1 || bus.core_err_o !== 1'b1 ||
        bus.core_rdata_o !== 32'd0) begin
      bad++; $display("FAIL oob_wr_ack rvalid=%b err=%b rdata=%h want 1/1/0",
        bus.core_rvalid_o, bus.core_err_o, bus.core_rdata_o);
    end
    tick();
  endtask

  task automatic test_core_random();
    logic we, ok;
    logic [31:0] a, wd, exp_rd;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: a = 32'(1020 + $urandom_range(0, 8));
        1: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 15));
      endcase
      wd = $urandom;
      ok = a < 1024;
      bus.core_req_i = 1; bus.core_we_i = we;
      bus.core_addr_i = a; bus.core_wdata_i = wd;
      @(negedge clk);
      total++;
      if (bus.core_gnt_o !== 1'b1 || bus.mem_addr_o !== a ||
          bus.mem_we_o !== (we & ok) ||
          (we && ok && bus.mem_wdata_o !== wd)) begin
        bad++; $display("FAIL core_issue n=%0d gnt=%b addr=%h we=%b want addr=%h we=%b",
          n, bus.core_gnt_o, bus.mem_addr_o, bus.mem_we_o, a, we & ok);
      end
      tick();
      bus.core_req_i = 0;
      exp_rd = (!we && ok) ? ref_mem[a[9:0]] : 32'd0;
      if (we && ok) ref_mem[a[9:0]] = wd;
      @(negedge clk);
      total++;
      if (bus.core_rvalid_o !== 1'b1 || bus.core_err_o !== !ok ||
          bus.core_rdata_o !== exp_rd) begin
        bad++; $display("FAIL core_ack n=%0d rvalid=%b err=%b rdata=%h want 1/%b/%h",
          n, bus.core_rvalid_o, bus.core_err_o, bus.core_rdata_o, !ok, exp_rd);
      end
      tick();
    end
    clr();
  endtask

  task automatic do_burst(input logic we, input logic [31:0] base,
                          input logic [3:0] len, input logic hold_core);
    logic [31:0] a, wd, exp_rd;
    logic ok, err_acc;
    int last_c;
    last_c = int'(len) + 1;
    err_acc = 0; exp_rd = 0;
    bus.dma_req_i = 1; bus.dma_we_i = we;
    bus.dma_addr_i = base; bus.dma_len_i = len;
    for (int c = 0; c <= last_c; c++) begin
      a = base + 32'(c);
      ok = a < 1024;
      wd = $urandom;
      bus.dma_wdata_i = wd;
      @(negedge clk);
      if (c < last_c) begin
        total++;
        if (bus.dma_beat_o !== 1'b1 || bus.dma_idx_o !== 4'(c) ||
            bus.dma_gnt_o !== (c == 0) || bus.dma_done_o !== 1'b0) begin
          bad++; $display("FAIL beat c=%0d beat=%b idx=%0d gnt=%b done=%b",
            c, bus.dma_beat_o, bus.dma_idx_o, bus.dma_gnt_o, bus.dma_done_o);
        end
        total++;
        if (bus.mem_addr_o !== a || bus.mem_we_o !== (we & ok) ||
            (we && ok && bus.mem_wdata_o !== wd)) begin
          bad++; $display("FAIL beat_mem c=%0d addr=%h we=%b want addr=%h we=%b",
            c, bus.mem_addr_o, bus.mem_we_o, a, we & ok);
        end
      end else begin
        total++;
        if (bus.dma_beat_o !== 1'b0 || bus.dma_done_o !== 1'b1) begin
          bad++; $display("FAIL done beat=%b done=%b want 0/1",
            bus.dma_beat_o, bus.dma_done_o);
        end
      end
      if (c > 0) begin
        total++;
        if (bus.dma_rvalid_o !== !we || (!we && bus.dma_rdata_o !== exp_rd)) begin
          bad++; $display("FAIL dma_rdata c=%0d rvalid=%b rdata=%h want %b/%h",
            c, bus.dma_rvalid_o, bus.dma_rdata_o, !we, exp_rd);
        end
      end
      total++;
      if (bus.dma_err_o !== err_acc) begin
        bad++; $display("FAIL dma_err c=%0d err=%b want %b", c, bus.dma_err_o, err_acc);
      end
      total++;
      if (bus.core_gnt_o !== (hold_core && c == last_c)) begin
        bad++; $display("FAIL core_holdoff c=%0d gnt=%b", c, bus.core_gnt_o);
      end
      if (c < last_c) begin
        if (!ok) err_acc = 1;
        exp_rd = ok ? ref_mem[a[9:0]] : 32'd0;
        if (we && ok) ref_mem[a[9:0]] = wd;
      end
      tick();
      if (c == 0) begin
        bus.dma_req_i = 0;
        if (hold_core) begin
          bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 32'd0;
        end
      end
    end
    bus.core_req_i = 0;
    if (hold_core) begin
      @(negedge clk);
      total++;
      if (bus.core_rvalid_o !== 1'b1 || bus.core_rdata_o !== ref_mem[0]) begin
        bad++; $display("FAIL core_after_burst rvalid=%b rdata=%h want 1/%h",
          bus.core_rvalid_o, bus.core_rdata_o, ref_mem[0]);
      end
      tick();
    end
    clr();
  endtask

  task automatic test_dma_write();
    do_burst(1'b1, 32'h10, 4'd3, 1'b1);
  endtask

  task automatic test_dma_read_len0();
    do_burst(1'b0, 32'h7, 4'd0, 1'b0);
  endtask

  task automatic test_dma_random();
    logic [31:0] base;
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0: base = 32'($urandom_range(1012, 1023));
        1: base = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: base = 32'($urandom_range(0, 1000));
      endcase
      do_burst(1'($urandom_range(0, 1)), base,
               4'($urandom_range(0, 15)), 1'b0);
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] wd;
    bus.dma_req_i = 1; bus.dma_we_i = 1;
    bus.dma_addr_i = 32'h40; bus.dma_len_i = 4'd5;
    for (int c = 0; c < 3; c++) begin
      wd = $urandom;
      bus.dma_wdata_i = wd;
      @(negedge clk);
      total++;
      if (bus.dma_beat_o !== 1'b1 || bus.dma_idx_o !== 4'(c)) begin
        bad++; $display("FAIL mid_beat c=%0d beat=%b idx=%0d",
          c, bus.dma_beat_o, bus.dma_idx_o);
      end
      if (c == 2) break;
      ref_mem[32'h40 + c] = wd;
      tick();
      bus.dma_req_i = 0;
    end
    #1 rst_n = 0;
    #1;
    total++;
    if ({bus.dma_beat_o, bus.mem_we_o, bus.mem_addr_o, bus.dma_idx_o,
         bus.core_gnt_o, bus.dma_done_o, bus.dma_err_o} !== '0) begin
      bad++; $display("FAIL mid_reset beat=%b we=%b addr=%h want 0",
        bus.dma_beat_o, bus.mem_we_o, bus.mem_addr_o);
    end
    clr();
    tick(); tick();
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (bus.dma_beat_o !== 1'b0 || bus.dma_done_o !== 1'b0 ||
          bus.mem_we_o !== 1'b0) begin
        bad++; $display("FAIL after_reset k=%0d beat=%b done=%b we=%b",
          k, bus.dma_beat_o, bus.dma_done_o, bus.mem_we_o);
      end
      tick();
    end
  endtask

  task automatic test_arbitration();
    logic last_core, exp_core;
    logic [3:0] len;
    last_core = 0;
    bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 32'd3;
    bus.dma_req_i = 1; bus.dma_we_i = 0; bus.dma_addr_i = 32'h20;
    for (int r = 0; r < 6; r++) begin
      len = 4'($urandom_range(0, 2));
      bus.dma_len_i = len;
`ifdef DMEM_ARB_RR_EN
      exp_core = !last_core;
`else
      exp_core = 1'b1;
`endif
      @(negedge clk);
      total++;
      if (bus.core_gnt_o !== exp_core || bus.dma_gnt_o !== !exp_core) begin
        bad++; $display("FAIL tie r=%0d core_gnt=%b dma_gnt=%b want %b/%b",
          r, bus.core_gnt_o, bus.dma_gnt_o, exp_core, !exp_core);
      end
      last_core = exp_core;
      tick();
      if (!exp_core) begin
        for (int j = 1; j <= int'(len); j++) begin
          @(negedge clk);
          total++;
          if (bus.dma_beat_o !== 1'b1 || bus.core_gnt_o !== 1'b0) begin
            bad++; $display("FAIL tie_burst r=%0d j=%0d beat=%b core_gnt=%b",
              r, j, bus.dma_beat_o, bus.core_gnt_o);
          end
          tick();
        end
      end
    end
    clr();
    tick(); tick();
  endtask

  task automatic test_mem_contents();
    int diffs;
    diffs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) diffs++;
    end
    total++;
    if (diffs != 0) begin
      bad++; $display("FAIL mem_contents words_differing=%0d want 0", diffs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
    test_reset();
    test_core_read();
    test_core_oob_write();
    test_core_random();
    test_dma_write();
    test_dma_read_len0();
    test_dma_random();
    test_reset_mid_burst();
    test_arbitration();
    test_mem_contents();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
